perf_monitor: RTL and testbench

PERF_MONITOR -- requirements
Module: perf_monitor

---
 rtl/perf_pkg.sv | 24 ++
 rtl/perf_sat_counter.sv | 43 ++++
 rtl/perf_monitor.sv | 103 ++++++++++
 tb/tb_perf_monitor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance monitor: FSM states, counter slots
// and default sizing.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } perfState_t;

  localparam int DEFAULT_CNT_W  = 32;
  localparam int DEFAULT_WINDOW = 2000;

  localparam int NUM_CNT    = 3;
  localparam int CNT_CYCLES = 0;
  localparam int CNT_INSTR  = 1;
  localparam int CNT_STALLS = 2;

  // Bits needed for a window position 0..window-1, never less than one.
  function automatic int winWidth(input int window);
    return (window > 1) ? $clog2(window) : 1;
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter with synchronous clear and a sticky overflow flag.
// Exposes the post-edge value so the owner can snapshot it on the same edge.
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] countNext,
  output logic             satNext
);

  logic [CNT_W-1:0] count;
  logic             sat;

  // sat records that an increment was lost because the counter was full.
  always_comb begin
    countNext = count;
    satNext   = sat;
    if (clr) begin
      countNext = '0;
      satNext   = 1'b0;
    end else if (inc) begin
      if (&count) begin
        satNext = 1'b1;
      end else begin
        countNext = count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      sat   <= 1'b0;
    end else begin
      count <= countNext;
      sat   <= satNext;
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Performance monitor: counts cycles, retired instructions and stall cycles
// over a measurement window and offers the totals through a valid/ready report.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int CNT_W  = DEFAULT_CNT_W,
  parameter int WINDOW = DEFAULT_WINDOW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             retire,
  input  logic             stall,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_cycles,
  output logic [CNT_W-1:0] rpt_instr,
  output logic [CNT_W-1:0] rpt_stalls,
  output logic             rpt_sat
);

  localparam int WIN_W = winWidth(WINDOW);

  perfState_t         state;
  logic [WIN_W-1:0]   winCnt;
  logic               winLast;
  logic               cntClr;
  logic [NUM_CNT-1:0] cntInc;
  logic [NUM_CNT-1:0] satNext;
  logic [CNT_W-1:0]   cntNext [NUM_CNT];

  // The window length is tracked separately so that a saturated cycle
  // counter cannot keep the monitor in RUN forever.
  assign winLast = (winCnt == WIN_W'(WINDOW - 1));
  assign cntClr  = (state == IDLE) && start;

  assign cntInc[CNT_CYCLES] = (state == RUN);
  assign cntInc[CNT_INSTR]  = (state == RUN) && retire;
  assign cntInc[CNT_STALLS] = (state == RUN) && stall;

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : gCnt
      perf_sat_counter #(.CNT_W(CNT_W)) uCnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (cntClr),
        .inc       (cntInc[gi]),
        .countNext (cntNext[gi]),
        .satNext   (satNext[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      winCnt     <= '0;
      rpt_valid  <= 1'b0;
      rpt_cycles <= '0;
      rpt_instr  <= '0;
      rpt_stalls <= '0;
      rpt_sat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            winCnt <= '0;
          end
        end
        RUN: begin
          winCnt <= winCnt + WIN_W'(1);
          // The final cycle is counted, so the snapshot takes the post-edge values.
          if (stop || winLast) begin
            state      <= REPORT;
            busy       <= 1'b0;
            rpt_valid  <= 1'b1;
            rpt_cycles <= cntNext[CNT_CYCLES];
            rpt_instr  <= cntNext[CNT_INSTR];
            rpt_stalls <= cntNext[CNT_STALLS];
            rpt_sat    <= |satNext;
          end
        end
        REPORT: begin
          if (rpt_ready) begin
            state     <= IDLE;
            rpt_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rpt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench for perf_monitor: a full-size instance plus a narrow
// instance (CNT_W=4, WINDOW=20) for saturation, against a counting model.
module tb_perf_monitor;

  localparam int WIN  = 2000;
  localparam int SW   = 4;
  localparam int SWIN = 20;
  localparam int SMAX = 15;

  logic clk = 1'b0;
  logic rst, start, stop, retire, stall, rpt_ready;
  logic start2, rpt_ready2;

  logic        busy, rpt_valid, rpt_sat;
  logic [31:0] rpt_cycles, rpt_instr, rpt_stalls;
  logic          busy2, rpt_valid2, rpt_sat2;
  logic [SW-1:0] rpt_cycles2, rpt_instr2, rpt_stalls2;

  int compared   = 0;
  int mismatched = 0;
  int expCycles, expInstr, expStalls, anomalies;

  always #5 clk = ~clk;

  perf_monitor #(.CNT_W(32), .WINDOW(WIN)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .retire(retire), .stall(stall),
    .busy(busy), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_cycles(rpt_cycles), .rpt_instr(rpt_instr), .rpt_stalls(rpt_stalls), .rpt_sat(rpt_sat)
  );

  perf_monitor #(.CNT_W(SW), .WINDOW(SWIN)) dutSmall (
    .clk(clk), .rst(rst), .start(start2), .stop(stop), .retire(retire), .stall(stall),
    .busy(busy2), .rpt_valid(rpt_valid2), .rpt_ready(rpt_ready2),
    .rpt_cycles(rpt_cycles2), .rpt_instr(rpt_instr2), .rpt_stalls(rpt_stalls2), .rpt_sat(rpt_sat2)
  );

  // Drives one window on the full-size instance and tallies the expected totals.
  // mode 0: retire every other cycle; 1: stall for first 300 cycles;
  // 2: random retire/stall; 3: random plus stray start pulses mid-window.
  task automatic run_big(input int stopAt, input int abortAt, input int mode, input bit withStop);
    start = 1'b1;
    stop  = withStop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    expCycles = 0; expInstr = 0; expStalls = 0; anomalies = 0;
    for (int k = 1; k <= WIN; k++) begin
      if (busy !== 1'b1 || rpt_valid !== 1'b0) anomalies++;
      case (mode)
        0:       begin retire = (k % 2 == 0); stall = 1'b0; end
        1:       begin retire = 1'($urandom_range(0, 1)); stall = (k <= 300); end
        default: begin retire = 1'($urandom_range(0, 1)); stall = 1'($urandom_range(0, 1)); end
      endcase
      start = (mode == 3) && (k == 50 || k == 777);
      stop  = (k == stopAt);
      expCycles++;
      expInstr  += int'(retire);
      expStalls += int'(stall);
      @(negedge clk);
      if (k == stopAt || k == abortAt) break;
    end
    retire = 1'b0; stall = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; stop = 1'b0; retire = 1'b0; stall = 1'b0; rpt_ready = 1'b0;
    start2 = 1'b0; rpt_ready2 = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    compared++; if (rpt_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got=%0b exp=0", rpt_valid); end
    compared++; if (rpt_cycles !== 32'd0) begin mismatched++; $display("FAIL reset_cycles got=%0d exp=0", rpt_cycles); end
    compared++; if (rpt_instr !== 32'd0) begin mismatched++; $display("FAIL reset_instr got=%0d exp=0", rpt_instr); end
    compared++; if (rpt_stalls !== 32'd0) begin mismatched++; $display("FAIL reset_stalls got=%0d exp=0", rpt_stalls); end
    compared++; if (rpt_sat !== 1'b0) begin mismatched++; $display("FAIL reset_sat got=%0b exp=0", rpt_sat); end
    compared++; if (rpt_valid2 !== 1'b0 || busy2 !== 1'b0) begin mismatched++; $display("FAIL reset_small got valid=%0b busy=%0b exp 0/0", rpt_valid2, busy2); end
    rst = 1'b0;
    stop = 1'b1; retire = 1'b1; stall = 1'b1;
    @(negedge clk);
    stop = 1'b0; retire = 1'b0; stall = 1'b0;
    @(negedge clk);
    compared++; if (busy !== 1'b0 || rpt_valid !== 1'b0) begin mismatched++; $display("FAIL idle_stop_ignored got busy=%0b valid=%0b exp 0/0", busy, rpt_valid); end
    $display("reset: busy=%0b valid=%0b", busy, rpt_valid);
  endtask

  task automatic test_full_window;
    rpt_ready = 1'b1;
    run_big(0, 0, 0, 1'b0);
    compared++; if (anomalies !== 0) begin mismatched++; $display("FAIL full_inwindow got=%0d bad cycles exp=0", anomalies); end
    compared++; if (rpt_valid !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("FAIL full_valid got valid=%0b busy=%0b exp 1/0", rpt_valid, busy); end
    compared++; if (rpt_cycles !== 32'd2000) begin mismatched++; $display("FAIL full_cycles got=%0d exp=2000", rpt_cycles); end
    compared++; if (rpt_instr !== 32'd1000) begin mismatched++; $display("FAIL full_instr got=%0d exp=1000", rpt_instr); end
    compared++; if (rpt_stalls !== 32'd0 || rpt_sat !== 1'b0) begin mismatched++; $display("FAIL full_stalls_sat got=%0d/%0b exp=0/0", rpt_stalls, rpt_sat); end
    $display("full window: cycles=%0d instr=%0d stalls=%0d sat=%0b", rpt_cycles, rpt_instr, rpt_stalls, rpt_sat);
    @(negedge clk);
    compared++; if (rpt_valid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL full_after_hs got valid=%0b busy=%0b exp 0/0", rpt_valid, busy); end
  endtask

  task automatic test_stop_early;
    rpt_ready = 1'b0;
    run_big(500, 0, 1, 1'b0);
    compared++; if (anomalies !== 0) begin mismatched++; $display("FAIL stop_inwindow got=%0d bad cycles exp=0", anomalies); end
    compared++; if (rpt_valid !== 1'b1) begin mismatched++; $display("FAIL stop_valid got=%0b exp=1", rpt_valid); end
    compared++; if (rpt_cycles !== 32'd500) begin mismatched++; $display("FAIL stop_cycles got=%0d exp=500", rpt_cycles); end
    compared++; if (rpt_stalls !== 32'd300) begin mismatched++; $display("FAIL stop_stalls got=%0d exp=300", rpt_stalls); end
    compared++; if (rpt_instr !== 32'(expInstr)) begin mismatched++; $display("FAIL stop_instr got=%0d exp=%0d", rpt_instr, expInstr); end
    $display("stop early: cycles=%0d instr=%0d stalls=%0d", rpt_cycles, rpt_instr, rpt_stalls);
  endtask

  task automatic test_backpressure;
    int unstable;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      retire = 1'b1; stall = 1'b1; start = (i == 3);
      if (rpt_valid !== 1'b1 || busy !== 1'b0 || rpt_cycles !== 32'd500 ||
          rpt_stalls !== 32'd300 || rpt_instr !== 32'(expInstr) || rpt_sat !== 1'b0) unstable++;
      @(negedge clk);
    end
    retire = 1'b0; stall = 1'b0; start = 1'b0;
    compared++; if (unstable !== 0) begin mismatched++; $display("FAIL hold_stable got=%0d unstable cycles exp=0", unstable); end
    compared++; if (rpt_valid !== 1'b1 || rpt_stalls !== 32'd300) begin mismatched++; $display("FAIL hold_end got valid=%0b stalls=%0d exp 1/300", rpt_valid, rpt_stalls); end
    rpt_ready = 1'b1;
    @(negedge clk);
    rpt_ready = 1'b0;
    compared++; if (rpt_valid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL hold_release got valid=%0b busy=%0b exp 0/0", rpt_valid, busy); end
    compared++; if (rpt_cycles !== 32'd500) begin mismatched++; $display("FAIL retain_cycles got=%0d exp=500", rpt_cycles); end
    $display("backpressure: released after 10 cycles, retained cycles=%0d", rpt_cycles);
  endtask

  task automatic test_saturation;
    int sStalls, bad;
    rpt_ready2 = 1'b1;
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    sStalls = 0; bad = 0;
    for (int k = 1; k <= SWIN; k++) begin
      if (rpt_valid2 !== 1'b0 || busy2 !== 1'b1) bad++;
      retire = 1'b1; stall = 1'($urandom_range(0, 1));
      sStalls += int'(stall);
      @(negedge clk);
    end
    retire = 1'b0; stall = 1'b0;
    compared++; if (bad !== 0) begin mismatched++; $display("FAIL sat_inwindow got=%0d bad cycles exp=0", bad); end
    compared++; if (rpt_valid2 !== 1'b1) begin mismatched++; $display("FAIL sat_valid got=%0b exp=1", rpt_valid2); end
    compared++; if (rpt_cycles2 !== SW'(SMAX)) begin mismatched++; $display("FAIL sat_cycles got=%0d exp=%0d", rpt_cycles2, SMAX); end
    compared++; if (rpt_instr2 !== SW'(SMAX)) begin mismatched++; $display("FAIL sat_instr got=%0d exp=%0d", rpt_instr2, SMAX); end
    compared++; if (rpt_stalls2 !== SW'((sStalls > SMAX) ? SMAX : sStalls)) begin mismatched++; $display("FAIL sat_stalls got=%0d exp=%0d", rpt_stalls2, (sStalls > SMAX) ? SMAX : sStalls); end
    compared++; if (rpt_sat2 !== 1'b1) begin mismatched++; $display("FAIL sat_flag got=%0b exp=1", rpt_sat2); end
    $display("saturation: cycles=%0d instr=%0d stalls=%0d sat=%0b", rpt_cycles2, rpt_instr2, rpt_stalls2, rpt_sat2);
    @(negedge clk);
    // A fresh start must clear the sticky flag; 12 cycles fit in 4 bits.
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      retire = 1'b1; stop = (k == 12);
      @(negedge clk);
    end
    retire = 1'b0; stop = 1'b0;
    compared++; if (rpt_valid2 !== 1'b1 || rpt_cycles2 !== SW'(12) || rpt_instr2 !== SW'(12)) begin mismatched++; $display("FAIL sat_short got valid=%0b cycles=%0d instr=%0d exp 1/12/12", rpt_valid2, rpt_cycles2, rpt_instr2); end
    compared++; if (rpt_sat2 !== 1'b0) begin mismatched++; $display("FAIL sat_cleared got=%0b exp=0", rpt_sat2); end
    $display("short narrow window: cycles=%0d sat=%0b", rpt_cycles2, rpt_sat2);
    @(negedge clk);
    rpt_ready2 = 1'b0;
  endtask

  task automatic test_rst_mid_run;
    rpt_ready = 1'b1;
    run_big(0, 100, 2, 1'b0);
    compared++; if (busy !== 1'b1 || anomalies !== 0) begin mismatched++; $display("FAIL rst_pre got busy=%0b bad=%0d exp 1/0", busy, anomalies); end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    compared++; if (busy !== 1'b0 || rpt_valid !== 1'b0) begin mismatched++; $display("FAIL rst_run_state got busy=%0b valid=%0b exp 0/0", busy, rpt_valid); end
    compared++; if (rpt_cycles !== 32'd0 || rpt_instr !== 32'd0 || rpt_stalls !== 32'd0 || rpt_sat !== 1'b0) begin mismatched++; $display("FAIL rst_run_rpt got %0d/%0d/%0d/%0b exp all 0", rpt_cycles, rpt_instr, rpt_stalls, rpt_sat); end
    repeat (3) @(negedge clk);
    compared++; if (busy !== 1'b0 || rpt_valid !== 1'b0) begin mismatched++; $display("FAIL rst_run_stays got busy=%0b valid=%0b exp 0/0", busy, rpt_valid); end
    rpt_ready = 1'b0;
    run_big(7, 0, 2, 1'b0);
    compared++; if (rpt_valid !== 1'b1 || rpt_cycles !== 32'd7) begin mismatched++; $display("FAIL rst_hs_pre got valid=%0b cycles=%0d exp 1/7", rpt_valid, rpt_cycles); end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    @(negedge clk);
    compared++; if (rpt_valid !== 1'b0 || busy !== 1'b0 || rpt_cycles !== 32'd0) begin mismatched++; $display("FAIL rst_hs got valid=%0b busy=%0b cycles=%0d exp 0/0/0", rpt_valid, busy, rpt_cycles); end
    $display("reset abort: busy=%0b valid=%0b cycles=%0d", busy, rpt_valid, rpt_cycles);
  endtask

  task automatic test_start_ignored;
    rpt_ready = 1'b1;
    run_big(0, 0, 3, 1'b1);
    compared++; if (anomalies !== 0) begin mismatched++; $display("FAIL ign_inwindow got=%0d bad cycles exp=0", anomalies); end
    compared++; if (rpt_valid !== 1'b1 || rpt_cycles !== 32'd2000) begin mismatched++; $display("FAIL ign_cycles got valid=%0b cycles=%0d exp 1/2000", rpt_valid, rpt_cycles); end
    compared++; if (rpt_instr !== 32'(expInstr) || rpt_stalls !== 32'(expStalls)) begin mismatched++; $display("FAIL ign_counts got %0d/%0d exp %0d/%0d", rpt_instr, rpt_stalls, expInstr, expStalls); end
    $display("start ignored: cycles=%0d instr=%0d stalls=%0d", rpt_cycles, rpt_instr, rpt_stalls);
    @(negedge clk);
  endtask

  task automatic test_random_back_to_back;
    int stopAt, waitCyc;
    for (int it = 0; it < 4; it++) begin
      stopAt = (it == 0) ? 1 : (it == 1) ? WIN : int'($urandom_range(2, WIN - 1));
      rpt_ready = 1'b0;
      run_big(stopAt, 0, 2, 1'b0);
      compared++; if (anomalies !== 0 || rpt_valid !== 1'b1) begin mismatched++; $display("FAIL rnd%0d_valid got valid=%0b bad=%0d exp 1/0", it, rpt_valid, anomalies); end
      compared++; if (rpt_cycles !== 32'(expCycles)) begin mismatched++; $display("FAIL rnd%0d_cycles got=%0d exp=%0d", it, rpt_cycles, expCycles); end
      compared++; if (rpt_instr !== 32'(expInstr)) begin mismatched++; $display("FAIL rnd%0d_instr got=%0d exp=%0d", it, rpt_instr, expInstr); end
      compared++; if (rpt_stalls !== 32'(expStalls) || rpt_sat !== 1'b0) begin mismatched++; $display("FAIL rnd%0d_stalls got=%0d/%0b exp=%0d/0", it, rpt_stalls, rpt_sat, expStalls); end
      $display("random window %0d: stop=%0d cycles=%0d instr=%0d stalls=%0d", it, stopAt, rpt_cycles, rpt_instr, rpt_stalls);
      waitCyc = int'($urandom_range(0, 5));
      repeat (waitCyc) @(negedge clk);
      rpt_ready = 1'b1;
      @(negedge clk);
      rpt_ready = 1'b0;
      compared++; if (rpt_valid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL rnd%0d_release got valid=%0b busy=%0b exp 0/0", it, rpt_valid, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_stop_early();
    test_backpressure();
    test_saturation();
    test_rst_mid_run();
    test_start_ignored();
    test_random_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
